link_stack: RTL

// - Parametrised return-address stack replacing the single link register: nested CALL pushes, RET pops.
// - Sits beside the PC/branch unit. Pushes take the return address, and top_data feeds the PC mux on RET.
// - Tracks fill level and reports overflow/underflow through sticky error flags for the control unit.

---
 rtl/link_stack_if.sv | 30 +++
 rtl/link_stack.sv | 111 +++++++++++
 2 files changed

// File: rtl/link_stack_if.sv
// Handshake bundle between the PC/branch unit and the return-address stack.
// The PC side uses the master modport; the stack itself uses the slave modport.
interface link_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             push_en;
  logic [WIDTH-1:0] push_data;
  logic             pop_en;
  logic             err_clr;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output flush, push_en, push_data, pop_en, err_clr,
    input  top_data, count, empty, full, ovf_err, unf_err
  );

  modport slave (
    input  flush, push_en, push_data, pop_en, err_clr,
    output top_data, count, empty, full, ovf_err, unf_err
  );
endinterface

// File: rtl/link_stack.sv
// Return-address stack: CALL pushes, RET pops, with sticky overflow/underflow flags.
// Define LINK_STACK_CIRCULAR_EN to overwrite the oldest entry on push-while-full.
module link_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  link_stack_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;
`ifdef LINK_STACK_CIRCULAR_EN
  logic [PW-1:0]    bot_q, bot_d;
`endif

  // wr_q points at the next free slot; the top entry sits one below it.
  assign top_idx  = wr_q - PW'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));

  assign bus.count    = cnt_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;
  assign bus.top_data = is_empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = bus.err_clr ? 1'b0 : ovf_q;
    unf_d = bus.err_clr ? 1'b0 : unf_q;
`ifdef LINK_STACK_CIRCULAR_EN
    bot_d = bot_q;
`endif
    if (bus.flush) begin
      cnt_d = '0;
`ifdef LINK_STACK_CIRCULAR_EN
      bot_d = wr_q;
`endif
    end else if (bus.push_en && bus.pop_en) begin
      if (!is_empty) begin
        mem_d[top_idx] = bus.push_data;
      end else begin
        mem_d[wr_q] = bus.push_data;
        wr_d        = wr_q + PW'(1);
        cnt_d       = CW'(1);
        unf_d       = 1'b1;
      end
    end else if (bus.push_en) begin
      if (!is_full) begin
        mem_d[wr_q] = bus.push_data;
        wr_d        = wr_q + PW'(1);
        cnt_d       = cnt_q + CW'(1);
      end else begin
`ifdef LINK_STACK_CIRCULAR_EN
        // When full the free slot and the oldest entry coincide, so the oldest is overwritten.
        mem_d[bot_q] = bus.push_data;
        wr_d         = bot_q + PW'(1);
        bot_d        = bot_q + PW'(1);
`else
        ovf_d = 1'b1;
`endif
      end
    end else if (bus.pop_en) begin
      if (!is_empty) begin
        wr_d  = top_idx;
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef LINK_STACK_CIRCULAR_EN
      bot_q <= '0;
`endif
    end else begin
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef LINK_STACK_CIRCULAR_EN
      bot_q <= bot_d;
`endif
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
